// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word block copy over a combinational-read data memory port
module mem_copy_engine #(
  parameter int N = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] src_addr,
  input  logic [N-1:0] dst_addr,
  input  logic [7:0]   len_words,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [N:0] LIM = (N+1)'(MEM_BYTES);
  state_t state_q, state_d;
  logic [N-1:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [7:0] rem_q, rem_d;
  logic err_q, err_d;
  logic [N:0] len_bytes, src_end, dst_end;
  logic reject;
  assign len_bytes = {{(N-9){1'b0}}, len_words, 2'b00};
  assign src_end = {1'b0, src_addr} + len_bytes;
  assign dst_end = {1'b0, dst_addr} + len_bytes;
  assign reject = (|src_addr[1:0]) | (|dst_addr[1:0]) | (src_end > LIM) | (dst_end > LIM);
  assign busy = (state_q == READ) || (state_q == WRITE);
  assign done = state_q == DONE;
  assign err = done & err_q;
  assign mem_we = state_q == WRITE;
  assign mem_addr = (state_q == READ) ? src_q : (state_q == WRITE) ? dst_q : '0;
  assign mem_wdata = (state_q == WRITE) ? buf_q : '0;
  // sequencing: accept/reject in IDLE, then alternate READ/WRITE per word until the count runs out
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    buf_d = buf_q;
    rem_d = rem_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        src_d = src_addr;
        dst_d = dst_addr;
        rem_d = len_words;
        err_d = reject;
        state_d = (reject || len_words == 8'd0) ? DONE : READ;
      end
      READ: begin
        buf_d = mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        src_d = src_q + N'(4);
        dst_d = dst_q + N'(4);
        rem_d = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? DONE : READ;
      end
      default: begin
        err_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // state and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      buf_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      buf_q <= buf_d;
      rem_q <= rem_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: randomized copies against a word-level reference memory with a write/done scoreboard
module tb_mem_copy_engine;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [7:0] len_words = 0;
  logic busy, done, err, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ra;
  int tests = 0, fails = 0, cyc = 0, busy_cnt = 0;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic e; int c; int b;} dn_t;
  wr_t wq[$];
  dn_t dq[$];

  mem_copy_engine #(.N(32), .MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ra = mem_addr[7:0];
  assign mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

  always @(negedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++) mem[ra + 8'(i)] = mem_wdata[8*i +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic void ref_wr(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) ref_mem[a+i] = v[8*i +: 8];
  endfunction

  function automatic logic [31:0] mem_rd(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem[a+i] = v[8*i +: 8];
    ref_wr(a, v);
  endtask

  always @(negedge clk) begin
    wr_t w;
    dn_t x;
    if (busy) busy_cnt++;
    if (mem_we) begin
      if (wq.size() == 0) chk("unexpected_write", mem_addr, 32'hxxxx_xxxx);
      else begin
        w = wq.pop_front();
        chk("write_addr", mem_addr, w.a);
        chk("write_data", mem_wdata, w.d);
      end
    end
    if (err && !done) chk("err_without_done", 32'(err), 32'd0);
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        x = dq.pop_front();
        chk("done_err", 32'(err), 32'(x.e));
        chk("done_cycle", 32'(cyc), 32'(x.c));
        chk("busy_cycles", 32'(busy_cnt), 32'(x.b));
      end
      busy_cnt = 0;
    end
    if (rst) busy_cnt = 0;
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                          input int rst_at, input bit extra);
    bit legal;
    int nw, tot;
    logic [31:0] v;
    legal = s[1:0] == 2'b00 && d[1:0] == 2'b00 &&
            (longint'(s) + 4 * l <= 256) && (longint'(d) + 4 * l <= 256);
    nw = legal ? l : 0;
    if (rst_at > 0 && rst_at / 2 < nw) nw = rst_at / 2;
    for (int k = 0; k < nw; k++) begin
      v = ref_rd(int'(s) + 4 * k);
      ref_wr(int'(d) + 4 * k, v);
      wq.push_back('{d + 32'(4 * k), v});
    end
    tot = (legal && l > 0) ? 2 * l + 1 : 1;
    if (rst_at == 0) dq.push_back('{!legal, cyc + tot, legal ? 2 * l : 0});
    src_addr = s;
    dst_addr = d;
    len_words = 8'(l);
    start = 1;
    @(negedge clk);
    start = 0;
    if (rst_at > 0) begin
      repeat (rst_at - 1) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      rst = 0;
      repeat (2) @(negedge clk);
    end else if (extra) begin
      @(negedge clk);
      src_addr = 32'h0;
      dst_addr = 32'hF0;
      len_words = 8'd1;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (tot) @(negedge clk);
    end else repeat (tot + 2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    ref_mem = mem;
    set_word(32'h0, 32'h11111111);
    set_word(32'h4, 32'h22222222);
    set_word(32'h8, 32'h33333333);
    set_word(32'hC, 32'h44444444);
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    rst = 0;
    @(negedge clk);
    run_copy(32'h00, 32'h40, 4, 0, 0);
    chk("copy_src_kept", mem_rd(32'hC), 32'h44444444);
    chk("copy_dst_last", mem_rd(32'h4C), 32'h44444444);
    run_copy(32'hF8, 32'h00, 2, 0, 0);
    run_copy(32'hF8, 32'h00, 3, 0, 0);
    run_copy(32'h02, 32'h10, 1, 0, 0);
    run_copy(32'h10, 32'h20, 0, 0, 0);
    set_word(32'h0, 32'hA);
    set_word(32'h4, 32'hB);
    run_copy(32'h00, 32'h04, 2, 0, 0);
    chk("overlap_w1", mem_rd(32'h4), 32'hA);
    chk("overlap_w2", mem_rd(32'h8), 32'hA);
    run_copy(32'h40, 32'h80, 4, 4, 0);
    run_copy(32'h80, 32'hC0, 2, 0, 0);
    run_copy(32'h00, 32'h60, 3, 0, 1);
    for (int n = 0; n < 25; n++) begin
      logic [31:0] s, d;
      int l, r, ms, md;
      r = int'($urandom_range(0, 9));
      s = 32'($urandom_range(0, 63)) * 4;
      d = 32'($urandom_range(0, 63)) * 4;
      if (r == 0) s = s | 32'($urandom_range(1, 3));
      if (r == 1) d = 32'hFFFF_FFFC;
      if (r >= 4) begin
        ms = (256 - int'(s)) / 4;
        md = (256 - int'(d)) / 4;
        l = int'($urandom_range(0, ms < md ? ms : md));
      end else l = int'($urandom_range(0, 40));
      run_copy(s, d, l, 0, 0);
    end
    repeat (4) @(negedge clk);
    chk("writes_pending", 32'(wq.size()), 32'd0);
    chk("dones_pending", 32'(dq.size()), 32'd0);
    for (int a = 0; a < 256; a += 4) chk($sformatf("mem_%02h", a), mem_rd(a), ref_rd(a));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator that drives the data-memory port (address / write-enable / write-data out, read-data in) to copy a run of 32-bit words from a source byte address to a destination byte address. It sits beside the CPU datapath in front of the byte-addressed 256-byte data memory. It is used for memory initialisation and test setup, such as replicating Fibonacci seed tables. The memory reads combinationally, and on the falling clock edge it writes a little-endian word at `Address..Address+3` when write-enable is high.

## Interface
- `N`, 32: data and address width.
- `MEM_BYTES`, 256: memory size in bytes, used for range checking.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a copy; sampled only in IDLE.
- `src_addr`  in  N  source byte address; must be 4-aligned.
- `dst_addr`  in  N  destination byte address; must be 4-aligned.
- `len_words`  in  8  number of words to copy, 0..255.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse with `done` when the request is rejected.
- `mem_addr`  out  N  drives memory `Address`.
- `mem_we`  out  1  drives memory `WE`.
- `mem_wdata`  out  N  drives memory `data`.
- `mem_rdata`  in  N  from memory `dataout`; combinational read of `mem_addr`.

## Operation
- One clock; reset is synchronous and active-high.
- FSM states: IDLE, READ, WRITE, DONE. Registers:
  - `src_r`, `dst_r` (N bits);
  - `remaining` (8 bits);
  - `buf` (N bits);
  - `err_r`.
- IDLE, with `start`=1, latches the operands and evaluates the request:
  - The request is rejected if `src_addr[1:0]`≠0, `dst_addr[1:0]`≠0, `src_addr`+4·`len_words` > `MEM_BYTES`, or `dst_addr`+4·`len_words` > `MEM_BYTES`.
  - The sums are computed N+1 bits wide, so no wrap.
  - Rejected request: go to DONE with `err_r`=1; no memory access.
  - `len_words`=0 and otherwise legal: go to DONE with `err_r`=0.
  - Otherwise: go to READ.
- READ:
  - Drives `mem_addr`=`src_r`, `mem_we`=0.
  - At the rising edge: `buf`←`mem_rdata`, then go to WRITE.
- WRITE:
  - Drives `mem_addr`=`dst_r`, `mem_we`=1, `mem_wdata`=`buf`.
  - At the rising edge: `src_r`+=4, `dst_r`+=4, `remaining`-=1.
  - If `remaining` was 1, go to DONE; else go to READ.
- DONE:
  - `done`=1 and `err`=`err_r`.
  - Go to IDLE at the next edge and clear `err_r`.
- Outputs in IDLE and DONE: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0. Memory outputs are decoded from the state and registers only, with no combinational path from `start`.
- Copy order is strictly ascending.
  - Overlapping ranges with `dst`>`src` propagate already-written words; this is defined behaviour.
  - `dst`==`src` rewrites identical data.
- `start` in READ, WRITE or DONE is ignored, not queued.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, all internal registers 0.
- `rst` asserted mid-copy:
  - The outputs above apply from the edge where `rst` is sampled.
  - The current WRITE cycle, if any, has already completed its falling-edge write.
  - Words already copied stay copied.
  - No `done` pulse.
- Legal copy of L≥1 words:
  - `start` is sampled at edge 0.
  - READ occupies cycle 1, WRITE cycle 2, and so on.
  - Word k is read in cycle 2k+1 and written in cycle 2k+2.
  - DONE occupies cycle 2L+1.
  - Total: 2L+1 cycles from `start` to the `done` cycle.
- L=0 or rejected request: DONE in cycle 1.
- Writes land on the falling edge inside the WRITE cycle. A READ of that address in the following cycle returns the new data.
- `busy` is 1 for exactly 2L cycles.
- The earliest accepted new `start` is sampled at the edge ending DONE + 1 cycle, i.e. in IDLE.

## Test plan
- Copy with memory preloaded `mem[0x00..0x0F]`=words 0x11111111, 0x22222222, 0x33333333, 0x44444444; `src`=0x00, `dst`=0x40, `len`=4:
  - `done` in cycle 9.
  - `busy` high for 8 cycles.
  - Words at 0x40..0x4C match the source; source is unchanged.
- Boundary: `src`=0xF8, `dst`=0x00, `len`=2 → accepted, 5 cycles. Same request with `len`=3 → `err`=1 and `done`=1 in cycle 1, `mem_we` never high.
- Misaligned `src`=0x02 (`len`=1) → `err` pulse in cycle 1, no write. `len`=0 with legal addresses → `done`=1, `err`=0 in cycle 1, no access.
- Overlap forward: `mem[0x00]`=0xA, `mem[0x04]`=0xB; `src`=0x00, `dst`=0x04, `len`=2 → `mem[0x04]`=0xA and `mem[0x08]`=0xA.
- `rst` asserted in cycle 4 of a `len`=4 copy:
  - Exactly 2 words are written.
  - `busy`=0 and `mem_we`=0 after the edge.
  - No `done` pulse.
  - A new `start` afterwards works normally.
- `start` pulsed during `busy` → ignored. Only one `done` pulse; write count equals the original `len`.
